// File: rtl/mux_nx1_scan_if.sv
// Channel-select bus for mux_nx1_scan: control and packed channel data in, registered selection out.
// The master drives enable/mode/sel/in_bus; the mux (slave) drives the out* group and wrap.
interface mux_nx1_scan_if #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
);
    logic                      enable;
    logic                      mode;
    logic [SEL_W-1:0]          sel;
    logic [CHANNELS*WIDTH-1:0] in_bus;
    logic [WIDTH-1:0]          out;
    logic [SEL_W-1:0]          out_idx;
    logic [CHANNELS-1:0]       out_onehot;
    logic                      out_valid;
    logic                      wrap;

    modport master (
        output enable, mode, sel, in_bus,
        input  out, out_idx, out_onehot, out_valid, wrap
    );

    modport slave (
        input  enable, mode, sel, in_bus,
        output out, out_idx, out_onehot, out_valid, wrap
    );
endinterface

// File: rtl/mux_nx1_scan.sv
// Registered N:1 mux with direct select or auto-scan (DWELL cycles per channel); latency 1 cycle.
// No backpressure: enable=0 zeroes the outputs and freezes the scan pointer in place.
module mux_nx1_scan #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3,
    parameter int DWELL    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mux_nx1_scan_if.slave bus
);
    localparam int DCNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0]  PTR_LAST  = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0]    r_ptr;
    logic [DCNT_W-1:0]   r_dcnt;
    logic [WIDTH-1:0]    r_out;
    logic [SEL_W-1:0]    r_idx;
    logic [CHANNELS-1:0] r_onehot;
    logic                r_valid;
    logic                r_wrap;
    logic                r_scan_last;

    logic [SEL_W-1:0]    w_ch;
    logic                w_legal;
    logic [WIDTH-1:0]    w_data;
    logic [CHANNELS-1:0] w_onehot;
    logic [SEL_W-1:0]    w_idx;
    logic                w_wrap;

    assign w_ch    = bus.mode ? r_ptr : bus.sel;
    assign w_legal = (w_ch <= PTR_LAST);
    assign w_idx   = w_legal ? w_ch : '0;

    // Compare against every legal index so an out-of-range select can never index past in_bus.
    always_comb begin
        w_data   = '0;
        w_onehot = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_ch == SEL_W'(k)) begin
                w_data      = bus.in_bus[k*WIDTH +: WIDTH];
                w_onehot[k] = 1'b1;
            end
        end
    end

    // Wrap only when the previous presented cycle was a valid scan of the last channel.
    assign w_wrap = bus.mode && (r_ptr == '0) && r_scan_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_dcnt      <= '0;
            r_out       <= '0;
            r_idx       <= '0;
            r_onehot    <= '0;
            r_valid     <= 1'b0;
            r_wrap      <= 1'b0;
            r_scan_last <= 1'b0;
        end else begin
            if (!bus.mode) begin
                r_ptr  <= '0;
                r_dcnt <= '0;
            end else if (bus.enable) begin
                if (r_dcnt == DCNT_LAST) begin
                    r_dcnt <= '0;
                    r_ptr  <= (r_ptr == PTR_LAST) ? '0 : r_ptr + 1'b1;
                end else begin
                    r_dcnt <= r_dcnt + 1'b1;
                end
            end

            if (bus.enable) begin
                r_out       <= w_data;
                r_idx       <= w_idx;
                r_onehot    <= w_onehot;
                r_valid     <= w_legal;
                r_wrap      <= w_wrap;
                r_scan_last <= bus.mode && w_legal && (w_ch == PTR_LAST);
            end else begin
                r_out       <= '0;
                r_onehot    <= '0;
                r_valid     <= 1'b0;
                r_wrap      <= 1'b0;
                r_scan_last <= 1'b0;
            end
        end
    end

    assign bus.out        = r_out;
    assign bus.out_idx    = r_idx;
    assign bus.out_onehot = r_onehot;
    assign bus.out_valid  = r_valid;
    assign bus.wrap       = r_wrap;
endmodule

// File: tb/tb_mux_nx1_scan.sv
// Directed bench for mux_nx1_scan: default 8-channel/DWELL=4 instance plus a 5-channel/DWELL=1 instance.
module tb_mux_nx1_scan;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mux_nx1_scan_if #(.WIDTH(8), .CHANNELS(8), .SEL_W(3)) bus8 ();
    mux_nx1_scan_if #(.WIDTH(8), .CHANNELS(5), .SEL_W(3)) bus5 ();

    mux_nx1_scan #(.WIDTH(8), .CHANNELS(8), .SEL_W(3), .DWELL(4)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .bus(bus8)
    );
    mux_nx1_scan #(.WIDTH(8), .CHANNELS(5), .SEL_W(3), .DWELL(1)) u_dut5 (
        .clk(clk), .rst_n(rst_n), .bus(bus5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus8.enable = 1'b0; bus8.mode = 1'b0; bus8.sel = '0;
        bus5.enable = 1'b0; bus5.mode = 1'b0; bus5.sel = '0;
        for (int k = 0; k < 8; k++) bus8.in_bus[k*8 +: 8] = 8'h10 + 8'(k);
        for (int k = 0; k < 5; k++) bus5.in_bus[k*8 +: 8] = 8'h20 + 8'(k);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus8.out !== 8'h00 || bus8.out_idx !== 3'd0 || bus8.out_onehot !== 8'h00 ||
            bus8.out_valid !== 1'b0 || bus8.wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset8: out=%h idx=%0d oh=%b vld=%b wrap=%b, want all zero",
                     bus8.out, bus8.out_idx, bus8.out_onehot, bus8.out_valid, bus8.wrap);
        end
        checks++;
        if (bus5.out !== 8'h00 || bus5.out_idx !== 3'd0 || bus5.out_onehot !== 5'b0 ||
            bus5.out_valid !== 1'b0 || bus5.wrap !== 1'b0) begin
            failures++;
            $display("FAIL reset5: out=%h idx=%0d oh=%b vld=%b wrap=%b, want all zero",
                     bus5.out, bus5.out_idx, bus5.out_onehot, bus5.out_valid, bus5.wrap);
        end
    endtask

    task automatic test_direct();
        do_reset();
        bus8.in_bus[3*8 +: 8] = 8'hA5;
        bus8.in_bus[7*8 +: 8] = 8'h3C;
        bus8.mode = 1'b0; bus8.sel = 3'd3; bus8.enable = 1'b1;
        tick();
        checks++;
        if (bus8.out !== 8'hA5 || bus8.out_idx !== 3'd3 || bus8.out_onehot !== 8'b0000_1000 ||
            bus8.out_valid !== 1'b1 || bus8.wrap !== 1'b0) begin
            failures++;
            $display("FAIL direct_sel3: out=%h idx=%0d oh=%b vld=%b wrap=%b, want A5 3 00001000 1 0",
                     bus8.out, bus8.out_idx, bus8.out_onehot, bus8.out_valid, bus8.wrap);
        end
        bus8.sel = 3'd7;
        tick();
        checks++;
        if (bus8.out !== 8'h3C || bus8.out_idx !== 3'd7 || bus8.out_onehot !== 8'b1000_0000 ||
            bus8.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL direct_sel7: out=%h idx=%0d oh=%b vld=%b, want 3C 7 10000000 1",
                     bus8.out, bus8.out_idx, bus8.out_onehot, bus8.out_valid);
        end
        bus8.in_bus[7*8 +: 8] = 8'h5A;
        tick();
        checks++;
        if (bus8.out !== 8'h5A) begin
            failures++;
            $display("FAIL direct_data_change: out=%h, want 5A", bus8.out);
        end
    endtask

    task automatic test_scan();
        int idx;
        do_reset();
        bus8.mode = 1'b1; bus8.enable = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            idx = ((cyc - 1) / 4) % 8;
            checks++;
            if (bus8.out !== 8'(8'h10 + idx) || bus8.out_idx !== 3'(idx) ||
                bus8.out_onehot !== 8'(1 << idx) || bus8.out_valid !== 1'b1 ||
                bus8.wrap !== (cyc == 33)) begin
                failures++;
                $display("FAIL scan cyc%0d: out=%h idx=%0d oh=%b vld=%b wrap=%b, want %h %0d wrap=%0d",
                         cyc, bus8.out, bus8.out_idx, bus8.out_onehot, bus8.out_valid,
                         bus8.wrap, 8'(8'h10 + idx), idx, (cyc == 33));
            end
        end
    endtask

    task automatic test_enable_freeze();
        do_reset();
        bus8.mode = 1'b1; bus8.enable = 1'b1;
        repeat (22) tick();
        checks++;
        if (bus8.out !== 8'h15 || bus8.out_idx !== 3'd5) begin
            failures++;
            $display("FAIL freeze_pre: out=%h idx=%0d, want 15 5", bus8.out, bus8.out_idx);
        end
        bus8.enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (bus8.out !== 8'h00 || bus8.out_valid !== 1'b0 || bus8.out_onehot !== 8'h00 ||
                bus8.wrap !== 1'b0 || bus8.out_idx !== 3'd5) begin
                failures++;
                $display("FAIL freeze_off%0d: out=%h vld=%b oh=%b wrap=%b idx=%0d, want 00 0 0 0 5",
                         i, bus8.out, bus8.out_valid, bus8.out_onehot, bus8.wrap, bus8.out_idx);
            end
        end
        bus8.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus8.out !== ((i < 2) ? 8'h15 : 8'h16) || bus8.out_valid !== 1'b1) begin
                failures++;
                $display("FAIL freeze_resume%0d: out=%h vld=%b, want %h 1",
                         i, bus8.out, bus8.out_valid, (i < 2) ? 8'h15 : 8'h16);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        do_reset();
        bus8.mode = 1'b1; bus8.enable = 1'b1;
        repeat (25) tick();
        checks++;
        if (bus8.out !== 8'h16) begin
            failures++;
            $display("FAIL rst_mid_pre: out=%h, want 16", bus8.out);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus8.out !== 8'h00 || bus8.out_idx !== 3'd0 || bus8.out_onehot !== 8'h00 ||
            bus8.out_valid !== 1'b0 || bus8.wrap !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_async: out=%h idx=%0d oh=%b vld=%b wrap=%b, want all zero",
                     bus8.out, bus8.out_idx, bus8.out_onehot, bus8.out_valid, bus8.wrap);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus8.out !== ((i < 4) ? 8'h10 : 8'h11) || bus8.wrap !== 1'b0) begin
                failures++;
                $display("FAIL rst_mid_restart%0d: out=%h wrap=%b, want %h 0",
                         i, bus8.out, bus8.wrap, (i < 4) ? 8'h10 : 8'h11);
            end
        end
    endtask

    task automatic test_non_pow2();
        logic [2:0] exp_idx [6];
        exp_idx = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        do_reset();
        bus5.enable = 1'b1; bus5.mode = 1'b0; bus5.sel = 3'd2;
        tick();
        checks++;
        if (bus5.out !== 8'h22 || bus5.out_idx !== 3'd2 || bus5.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL np2_sel2: out=%h idx=%0d vld=%b, want 22 2 1",
                     bus5.out, bus5.out_idx, bus5.out_valid);
        end
        bus5.sel = 3'd6;
        tick();
        checks++;
        if (bus5.out !== 8'h00 || bus5.out_idx !== 3'd0 || bus5.out_valid !== 1'b0 ||
            bus5.out_onehot !== 5'b0) begin
            failures++;
            $display("FAIL np2_illegal: out=%h idx=%0d vld=%b oh=%b, want 00 0 0 00000",
                     bus5.out, bus5.out_idx, bus5.out_valid, bus5.out_onehot);
        end
        bus5.mode = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (bus5.out_idx !== exp_idx[i] || bus5.out !== 8'h20 + 8'(exp_idx[i]) ||
                bus5.out_valid !== 1'b1 || bus5.wrap !== (i == 5)) begin
                failures++;
                $display("FAIL np2_scan%0d: idx=%0d out=%h vld=%b wrap=%b, want %0d wrap=%0d",
                         i, bus5.out_idx, bus5.out, bus5.out_valid, bus5.wrap, exp_idx[i], (i == 5));
            end
        end
    endtask

    task automatic test_mode_switch();
        do_reset();
        bus8.mode = 1'b1; bus8.enable = 1'b1;
        repeat (17) tick();
        checks++;
        if (bus8.out !== 8'h14) begin
            failures++;
            $display("FAIL mode_pre: out=%h, want 14", bus8.out);
        end
        bus8.mode = 1'b0; bus8.sel = 3'd2;
        tick();
        checks++;
        if (bus8.out !== 8'h12 || bus8.out_idx !== 3'd2 || bus8.out_valid !== 1'b1) begin
            failures++;
            $display("FAIL mode_direct: out=%h idx=%0d vld=%b, want 12 2 1",
                     bus8.out, bus8.out_idx, bus8.out_valid);
        end
        bus8.mode = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (bus8.out !== ((i < 4) ? 8'h10 : 8'h11) || bus8.wrap !== 1'b0) begin
                failures++;
                $display("FAIL mode_rescan%0d: out=%h wrap=%b, want %h 0",
                         i, bus8.out, bus8.wrap, (i < 4) ? 8'h10 : 8'h11);
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan();
        test_enable_freeze();
        test_reset_mid_scan();
        test_non_pow2();
        test_mode_switch();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
